// File: rtl/sipo_word_feeder_if.sv
// Word-feeder bus: producer side pushes words and holds the stream;
// feeder side returns the serial bit stream and FIFO status.
interface sipo_word_feeder_if #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             hold;
    logic             serial_out;
    logic             shift_out;
    logic             word_done;
    logic             busy;
    logic [CW-1:0]    fifo_count;

    modport master (
        output in_data, in_valid, hold,
        input  in_ready, serial_out, shift_out, word_done, busy, fifo_count
    );

    modport slave (
        input  in_data, in_valid, hold,
        output in_ready, serial_out, shift_out, word_done, busy, fifo_count
    );
endinterface

// File: rtl/sipo_word_feeder.sv
// Buffers parallel words in a small FIFO and serializes them MSB-first
// as a bit/strobe pair for a downstream serial-in/parallel-out register.
module sipo_word_feeder #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    sipo_word_feeder_if.slave bus
);
    localparam int  CW     = $clog2(FIFO_DEPTH + 1);
    localparam int  PW     = $clog2(FIFO_DEPTH);
    localparam int  BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int  GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam bit  NO_GAP = (GAP_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BW-1:0]    bitcnt_q;
    logic [GW-1:0]    gapcnt_q;

    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             have_s;
    logic             last_bit_s;
    logic             gap_end_s;
    logic [WIDTH-1:0] head_s;

    // Handshake and pop decisions; all use the registered occupancy, so a
    // word pushed this cycle is never popped before the next edge.
    always_comb begin
        in_ready_s = (count_q < CW'(FIFO_DEPTH)) && !reset;
        push_s     = bus.in_valid && in_ready_s;
        have_s     = (count_q != {CW{1'b0}});
        head_s     = mem_q[rd_ptr_q];
        last_bit_s = (state_q == ST_SHIFT) && (bitcnt_q == BW'(WIDTH - 1)) && !bus.hold;
        gap_end_s  = (state_q == ST_GAP) && (gapcnt_q == GW'(GAP_CYCLES - 1));
        pop_s      = 1'b0;
        case (state_q)
            ST_IDLE:  pop_s = have_s && !bus.hold;
            ST_SHIFT: pop_s = last_bit_s && NO_GAP && have_s;
            ST_GAP:   pop_s = gap_end_s && have_s && !bus.hold;
            default:  pop_s = 1'b0;
        endcase
    end

    // FIFO storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // FIFO pointers/occupancy plus the serializer state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        shreg_q  <= head_s;
                        bitcnt_q <= '0;
                        state_q  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!bus.hold) begin
                        if (last_bit_s && pop_s) begin
                            // Zero-bubble reload of the next word.
                            shreg_q  <= head_s;
                            bitcnt_q <= '0;
                        end else begin
                            shreg_q  <= {shreg_q[WIDTH-2:0], 1'b0};
                            bitcnt_q <= bitcnt_q + BW'(1);
                        end
                        if (last_bit_s && !NO_GAP) begin
                            gapcnt_q <= '0;
                            state_q  <= ST_GAP;
                        end else if (last_bit_s && !pop_s) begin
                            bitcnt_q <= '0;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    gapcnt_q <= gapcnt_q + GW'(1);
                    if (gap_end_s) begin
                        if (pop_s) begin
                            shreg_q  <= head_s;
                            bitcnt_q <= '0;
                            state_q  <= ST_SHIFT;
                        end else begin
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.shift_out  = (state_q == ST_SHIFT) && !bus.hold;
    assign bus.serial_out = shreg_q[WIDTH-1];
    assign bus.word_done  = last_bit_s;
    assign bus.busy       = (state_q != ST_IDLE) || have_s;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_sipo_word_feeder.sv
// Drives a back-to-back feeder and a GAP_CYCLES=2 feeder with the same inputs
// and checks both against a queue-based model every cycle.
module tb_sipo_word_feeder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hold = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    bit         chk_en = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    sipo_word_feeder_if #(.WIDTH(8), .FIFO_DEPTH(4)) if0 ();
    sipo_word_feeder_if #(.WIDTH(8), .FIFO_DEPTH(4)) if2 ();

    assign if0.in_data = in_data;  assign if2.in_data = in_data;
    assign if0.in_valid = in_valid; assign if2.in_valid = in_valid;
    assign if0.hold = hold;        assign if2.hold = hold;

    sipo_word_feeder #(.WIDTH(8), .FIFO_DEPTH(4), .GAP_CYCLES(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    sipo_word_feeder #(.WIDTH(8), .FIFO_DEPTH(4), .GAP_CYCLES(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

    logic       so [2], sh [2], wd [2], bz [2], rdy [2];
    logic [2:0] fc [2];
    assign so[0] = if0.serial_out; assign so[1] = if2.serial_out;
    assign sh[0] = if0.shift_out;  assign sh[1] = if2.shift_out;
    assign wd[0] = if0.word_done;  assign wd[1] = if2.word_done;
    assign bz[0] = if0.busy;       assign bz[1] = if2.busy;
    assign rdy[0] = if0.in_ready;  assign rdy[1] = if2.in_ready;
    assign fc[0] = if0.fifo_count; assign fc[1] = if2.fifo_count;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model: a word queue, the word on the wire, bits already sent, and
    // the remaining bubble cycles before the next word may start.
    logic [7:0] mq [2][$];
    logic [7:0] cur [2];
    int         sent [2];
    bit         active [2];
    int         gap_left [2];
    int         gapv [2] = '{0, 2};

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int  n;
                bit  push;
                check($sformatf("shift_out[%0d]@%0t", i, $time), 32'(sh[i]), 32'(active[i] && !hold));
                check($sformatf("serial_out[%0d]@%0t", i, $time), 32'(so[i]),
                      active[i] ? 32'(cur[i][7-sent[i]]) : 32'd0);
                check($sformatf("word_done[%0d]@%0t", i, $time), 32'(wd[i]),
                      32'(active[i] && !hold && sent[i] == 7));
                check($sformatf("fifo_count[%0d]@%0t", i, $time), 32'(fc[i]), 32'(mq[i].size()));
                check($sformatf("in_ready[%0d]@%0t", i, $time), 32'(rdy[i]), 32'(mq[i].size() < 4 && !reset));
                check($sformatf("busy[%0d]@%0t", i, $time), 32'(bz[i]),
                      32'(active[i] || gap_left[i] > 0 || mq[i].size() > 0));
                // advance model across the coming edge
                if (reset) begin
                    mq[i].delete();
                    active[i] = 1'b0; sent[i] = 0; gap_left[i] = 0;
                end else begin
                    n = mq[i].size();
                    push = in_valid && (n < 4);
                    if (active[i]) begin
                        if (!hold) begin
                            if (sent[i] == 7) begin
                                if (gapv[i] > 0) begin active[i] = 1'b0; gap_left[i] = gapv[i]; end
                                else if (n > 0) begin cur[i] = mq[i].pop_front(); sent[i] = 0; end
                                else active[i] = 1'b0;
                            end else sent[i]++;
                        end
                    end else if (gap_left[i] > 0) begin
                        if (gap_left[i] == 1) begin
                            gap_left[i] = 0;
                            if (n > 0 && !hold) begin cur[i] = mq[i].pop_front(); active[i] = 1'b1; sent[i] = 0; end
                        end else gap_left[i]--;
                    end else if (n > 0 && !hold) begin
                        cur[i] = mq[i].pop_front(); active[i] = 1'b1; sent[i] = 0;
                    end
                    if (push) mq[i].push_back(in_data);
                end
            end
        end
    end

    // Strobe capture used by the literal checks.
    logic bitv [2][64];
    int   ccyc [2][64];
    logic bzh [2][64], rdyh [2][64];
    int   n_st [2], n_dn [2], d_first [2];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic collect(input int ncyc);
        for (int i = 0; i < 2; i++) begin n_st[i] = 0; n_dn[i] = 0; d_first[i] = -1; end
        for (int c = 0; c < ncyc && c < 64; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                bzh[i][c] = bz[i];
                rdyh[i][c] = rdy[i];
                if (sh[i]) begin
                    if (n_st[i] < 64) begin bitv[i][n_st[i]] = so[i]; ccyc[i][n_st[i]] = c; end
                    n_st[i]++;
                end
                if (wd[i]) begin
                    if (n_dn[i] == 0) d_first[i] = n_st[i];
                    n_dn[i]++;
                end
            end
        end
    endtask

    function automatic logic [7:0] wordof(input int i, input int k);
        logic [7:0] w = 8'h00;
        for (int j = 0; j < 8; j++) w = {w[6:0], (k*8+j < n_st[i]) ? bitv[i][k*8+j] : 1'b0};
        return w;
    endfunction

    initial begin
        int acc;
        int hc;
        int nb;
        logic [7:0] wv;
        int fz;
        for (int i = 0; i < 2; i++) begin active[i] = 1'b0; sent[i] = 0; gap_left[i] = 0; cur[i] = 8'h00; end
        step();
        chk_en = 1'b1;
        @(negedge clk);
        check("ready_in_reset", 32'(rdy[0]), 32'd0);
        step(); reset = 1'b0;
        @(negedge clk);
        check("rst_shift", 32'(sh[0]), 32'd0);
        check("rst_busy", 32'(bz[0]), 32'd0);
        check("rst_count", 32'(fc[0]), 32'd0);

        // single word A5
        step();
        fork
            collect(16);
            begin in_valid = 1'b1; in_data = 8'hA5; step(); in_valid = 1'b0; end
        join
        check("a5_strobes", 32'(n_st[0]), 32'd8);
        check("a5_word", 32'(wordof(0, 0)), 32'hA5);
        check("a5_done_at", 32'(d_first[0]), 32'd8);
        check("a5_busy_after", (n_st[0] == 8) ? 32'(bzh[0][ccyc[0][7] + 1]) : 32'hFFFF, 32'd0);
        check("a5_gap_word", 32'(wordof(1, 0)), 32'hA5);

        // back-to-back 3C F0 81
        step();
        fork
            collect(50);
            begin
                in_valid = 1'b1; in_data = 8'h3C; step();
                in_data = 8'hF0; step();
                in_data = 8'h81; step();
                in_valid = 1'b0;
            end
        join
        check("b2b_strobes", 32'(n_st[0]), 32'd24);
        check("b2b_contig", (n_st[0] == 24) ? 32'(ccyc[0][23] - ccyc[0][0]) : 32'hFFFF, 32'd23);
        check("b2b_w0", 32'(wordof(0, 0)), 32'h3C);
        check("b2b_w1", 32'(wordof(0, 1)), 32'hF0);
        check("b2b_w2", 32'(wordof(0, 2)), 32'h81);
        check("gap_bubbles", (n_st[1] >= 9) ? 32'(ccyc[1][8] - ccyc[1][7] - 1) : 32'hFFFF, 32'd2);
        check("gap_w1", 32'(wordof(1, 1)), 32'hF0);

        // FIFO full under hold
        step(); hold = 1'b1; reset = 1'b1; step(); reset = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(k);
            @(negedge clk);
            if (rdy[0]) acc++;
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("full_accepted", 32'(acc), 32'd4);
        check("full_count", 32'(fc[0]), 32'd4);
        check("full_ready", 32'(rdy[0]), 32'd0);
        step(); hold = 1'b0;
        collect(45);
        check("full_ready_release", 32'(rdyh[0][0]), 32'd0);
        check("full_ready_after_pop", 32'(rdyh[0][1]), 32'd1);
        check("full_strobes", 32'(n_st[0]), 32'd32);
        for (int k = 0; k < 4; k++) check($sformatf("full_w%0d", k), 32'(wordof(0, k)), 32'h10 + 32'(k));

        // hold for 3 cycles after bit 3 of C3
        step(); in_valid = 1'b1; in_data = 8'hC3; step(); in_valid = 1'b0;
        nb = 0; hc = 0; wv = 8'h00; fz = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sh[0]) begin wv = {wv[6:0], so[0]}; nb++; end
            if (hold && !sh[0] && so[0] == 1'b0) fz++;
            step();
            hold = (nb >= 3 && hc < 3);
            if (hold) hc++;
        end
        hold = 1'b0;
        check("hold_strobes", 32'(nb), 32'd8);
        check("hold_word", 32'(wv), 32'hC3);
        check("hold_frozen", 32'(fz), 32'd3);

        // reset mid-word with two words queued
        step();
        in_valid = 1'b1; in_data = 8'hAA; step();
        in_data = 8'hBB; step();
        in_data = 8'hCC; step();
        in_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_queued", 32'(fc[0]), 32'd2);
        check("midrst_shifting", 32'(sh[0]), 32'd1);
        step(); reset = 1'b0;
        @(negedge clk);
        check("midrst_shift", 32'(sh[0]), 32'd0);
        check("midrst_count", 32'(fc[0]), 32'd0);
        check("midrst_busy", 32'(bz[0]), 32'd0);
        step();
        fork
            collect(16);
            begin in_valid = 1'b1; in_data = 8'h5A; step(); in_valid = 1'b0; end
        join
        check("post_rst_strobes", 32'(n_st[0]), 32'd8);
        check("post_rst_word", 32'(wordof(0, 0)), 32'h5A);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            in_valid = ($urandom % 3) != 0;
            in_data  = 8'($urandom);
            hold     = ($urandom % 6) == 0;
            reset    = ($urandom % 200) == 0;
        end
        step();
        in_valid = 1'b0; hold = 1'b0; reset = 1'b0;
        repeat (60) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
